// File: rtl/cheshire_eoc_pkg.sv
// Shared definitions for the end-of-computation reporter: register map,
// STATUS bit layout, FSM state encoding and the register response bundle.
package cheshire_eoc_pkg;

    localparam int unsigned AddrWidth = 4;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned PcWidth   = 64;

    localparam logic [AddrWidth-1:0] ADDR_EXIT   = 4'h0;
    localparam logic [AddrWidth-1:0] ADDR_STATUS = 4'h4;
    localparam logic [AddrWidth-1:0] ADDR_LIMIT  = 4'h8;

    localparam int unsigned STATUS_RUNNING = 0;
    localparam int unsigned STATUS_DONE    = 1;
    localparam int unsigned STATUS_TIMEOUT = 2;

    typedef enum logic [1:0] {
        EOC_IDLE,
        EOC_RUN,
        EOC_DONE,
        EOC_TIMEOUT
    } eoc_state_e;

    typedef enum logic [1:0] {
        SEL_EXIT,
        SEL_STATUS,
        SEL_LIMIT,
        SEL_NONE
    } reg_sel_e;

    typedef struct packed {
        logic                 valid;
        logic                 error;
        logic [DataWidth-1:0] rdata;
    } rsp_t;

    // Misaligned and out-of-range offsets all fall through to SEL_NONE.
    function automatic reg_sel_e decode_addr(input logic [AddrWidth-1:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_EXIT:   sel = SEL_EXIT;
            ADDR_STATUS: sel = SEL_STATUS;
            ADDR_LIMIT:  sel = SEL_LIMIT;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [DataWidth-1:0] status_word(input eoc_state_e state);
        logic [DataWidth-1:0] word;
        word                 = '0;
        word[STATUS_RUNNING] = (state == EOC_RUN);
        word[STATUS_DONE]    = (state == EOC_DONE);
        word[STATUS_TIMEOUT] = (state == EOC_TIMEOUT);
        return word;
    endfunction

endpackage

// File: rtl/cheshire_eoc_stall_cnt.sv
// Stall timer: counts cycles since the committed PC last changed and flags
// expiry once the count reaches a non-zero limit.
module cheshire_eoc_stall_cnt
    import cheshire_eoc_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 commit_valid,
    input  logic [PcWidth-1:0]   pc,
    input  logic [DataWidth-1:0] limit,
    output logic                 expired
);

    logic [PcWidth-1:0]   last_pc_q;
    logic [DataWidth-1:0] count_q;
    logic                 pc_moved;
    logic                 count_zero;
    logic                 count_max;

    assign pc_moved   = commit_valid && (pc != last_pc_q);
    assign count_max  = (count_q == '1);
    // A zero limit disables the timer, so the count is pinned there too.
    assign count_zero = clear || (enable && pc_moved) || (limit == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_pc_q <= '0;
            count_q   <= '0;
        end else begin
            if ((enable || clear) && commit_valid) begin
                last_pc_q <= pc;
            end
            if (count_zero) begin
                count_q <= '0;
            end else if (enable && !count_max) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign expired = enable && (limit != '0) && (count_q >= limit);

endmodule

// File: rtl/cheshire_eoc_reporter.sv
// End-of-computation reporter: watches core commits for PC stalls and exposes
// an EXIT/STATUS/LIMIT register file that latches the final exit code.
//
// state   | meaning
// IDLE    | waiting for the first commit or an early EXIT write
// RUN     | core committing; stall timer armed when LIMIT != 0
// DONE    | software reported an exit code (terminal until reset)
// TIMEOUT | PC stalled for LIMIT cycles, TimeoutCode reported (terminal)
module cheshire_eoc_reporter
    import cheshire_eoc_pkg::*;
#(
    parameter int unsigned TimeoutDefault = 10000,
    parameter logic [30:0] TimeoutCode    = 31'h0DEAD
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 error_o,
    input  logic                 commit_valid_i,
    input  logic [PcWidth-1:0]   commit_pc_i,
    output logic                 eoc_o,
    output logic [DataWidth-1:0] exit_code_o
);

    eoc_state_e           state_q, state_d;
    logic [DataWidth-1:0] exit_q, exit_d;
    logic [DataWidth-1:0] limit_q, limit_d;
    rsp_t                 rsp_q, rsp_d;
    reg_sel_e             sel;
    logic                 access_err;
    logic                 wr_exit;
    logic                 wr_limit;
    logic                 exit_set;
    logic                 cnt_enable;
    logic                 cnt_clear;
    logic                 cnt_expired;

    assign sel        = decode_addr(addr_i);
    assign access_err = req_i && ((sel == SEL_NONE) || (we_i && (sel == SEL_STATUS)));
    assign wr_exit    = req_i && we_i && (sel == SEL_EXIT);
    assign wr_limit   = req_i && we_i && (sel == SEL_LIMIT);
    assign exit_set   = wr_exit && wdata_i[0];

    assign limit_d = wr_limit ? wdata_i : limit_q;

    // Software exit takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_d = state_q;
        exit_d  = exit_q;
        case (state_q)
            EOC_IDLE: begin
                if (exit_set) begin
                    state_d = EOC_DONE;
                    exit_d  = wdata_i;
                end else if (commit_valid_i) begin
                    state_d = EOC_RUN;
                end
            end
            EOC_RUN: begin
                if (exit_set) begin
                    state_d = EOC_DONE;
                    exit_d  = wdata_i;
                end else if (cnt_expired) begin
                    state_d = EOC_TIMEOUT;
                    exit_d  = {TimeoutCode, 1'b1};
                end
            end
            EOC_DONE:    state_d = EOC_DONE;
            EOC_TIMEOUT: state_d = EOC_TIMEOUT;
            default:     state_d = EOC_IDLE;
        endcase
    end

    assign cnt_enable = (state_q == EOC_RUN);
    // The first commit seeds last_pc, so it shares the clear path with LIMIT writes.
    assign cnt_clear  = wr_limit || ((state_q == EOC_IDLE) && commit_valid_i);

    cheshire_eoc_stall_cnt u_stall_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable       (cnt_enable),
        .clear        (cnt_clear),
        .commit_valid (commit_valid_i),
        .pc           (commit_pc_i),
        .limit        (limit_q),
        .expired      (cnt_expired)
    );

    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = req_i;
        rsp_d.error = access_err;
        if (req_i && !we_i && !access_err) begin
            case (sel)
                SEL_EXIT:   rsp_d.rdata = exit_q;
                SEL_STATUS: rsp_d.rdata = status_word(state_q);
                SEL_LIMIT:  rsp_d.rdata = limit_q;
                default:    rsp_d.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EOC_IDLE;
            exit_q  <= '0;
            limit_q <= TimeoutDefault;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            exit_q  <= exit_d;
            limit_q <= limit_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rvalid_o    = rsp_q.valid;
    assign error_o     = rsp_q.error;
    assign rdata_o     = rsp_q.rdata;
    assign eoc_o       = (state_q == EOC_DONE) || (state_q == EOC_TIMEOUT);
    assign exit_code_o = eoc_o ? exit_q : '0;

endmodule
